// File: rtl/flash_writer.sv
`default_nettype none
// ============================================================================
//  Module      : flash_writer
//  Description : Wishbone-fronted SPI NOR writer. Turns a single Wishbone
//                write into WREN, PAGE PROGRAM (4 bytes) or 4 KB SECTOR
//                ERASE, then polls RDSR until WIP clears or a poll limit is
//                reached. Reads return {23'b0, err, last status byte}.
//  Revision    : 1.0 - initial release
// ============================================================================
module flash_writer #(
    parameter int          CS_GAP     = 2,
    parameter logic [23:0] POLL_LIMIT = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [21:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_erase,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic        o_busy,
    output logic        o_spi_cs_n,
    output logic        o_spi_sck,
    output logic        o_spi_mosi,
    input  logic        i_spi_miso
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SHORT    = 3'd1,
        S_WREN     = 3'd2,
        S_GAP_CMD  = 3'd3,
        S_CMD      = 3'd4,
        S_GAP_POLL = 3'd5,
        S_POLL     = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    localparam logic [6:0] GAP_LAST = 7'(CS_GAP - 1);
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_PP    = 8'h02;
    localparam logic [7:0] OP_SE    = 8'h20;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    state_t      state;
    state_t      next_state;
    logic [6:0]  bit_cnt;
    logic [23:0] poll_cnt;
    logic [63:0] shreg;
    logic [6:0]  rx;
    logic [7:0]  status;
    logic        err;
    logic [21:0] addr;
    logic [31:0] data;
    logic        erase;

    logic        accept;
    logic        bad_write;
    logic        shifting;
    logic [6:0]  cmd_bits;
    logic [23:0] poll_next;
    logic [23:0] byte_addr;

    assign accept    = (state == S_IDLE) && i_wb_cyc && i_wb_stb;
    assign bad_write = i_wb_we && !i_erase && (i_wb_sel != 4'b1111);
    assign shifting  = (state == S_WREN) || (state == S_CMD) || (state == S_POLL);
    assign cmd_bits  = erase ? 7'd32 : 7'd64;
    assign poll_next = (poll_cnt == 24'hFFFFFF) ? poll_cnt : poll_cnt + 24'd1;
    // Sector erase addresses are 4 KB aligned, so the low 12 byte-address bits drop.
    assign byte_addr = erase ? {addr[21:10], 12'h000} : {addr, 2'b00};
    assign o_wb_data = {23'd0, err, status};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and SPI / Wishbone outputs
    always_comb begin
        next_state = state;
        o_wb_stall = 1'b1;
        o_busy     = 1'b1;
        o_wb_ack   = 1'b0;
        o_spi_cs_n = 1'b1;
        o_spi_sck  = 1'b0;
        case (state)
            S_IDLE: begin
                o_wb_stall = 1'b0;
                o_busy     = 1'b0;
                if (accept) begin
                    next_state = (!i_wb_we || bad_write) ? S_SHORT : S_WREN;
                end
            end
            S_SHORT: begin
                o_wb_ack   = 1'b1;
                next_state = S_IDLE;
            end
            S_WREN: begin
                if (bit_cnt == 7'd8) next_state = S_GAP_CMD;
            end
            S_GAP_CMD: begin
                if (bit_cnt == GAP_LAST) next_state = S_CMD;
            end
            S_CMD: begin
                if (bit_cnt == cmd_bits) next_state = S_GAP_POLL;
            end
            S_GAP_POLL: begin
                if (bit_cnt == GAP_LAST) next_state = S_POLL;
            end
            S_POLL: begin
                // Last bit cycle: miso carries status bit 0 (WIP).
                if (bit_cnt == 7'd16) begin
                    next_state = (!i_spi_miso || (poll_next >= POLL_LIMIT)) ? S_DONE : S_GAP_POLL;
                end
            end
            S_DONE: begin
                o_wb_ack   = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        // Count 0 of each transfer state is the chip-select setup cycle.
        if (shifting) begin
            o_spi_cs_n = 1'b0;
            o_spi_sck  = (bit_cnt != 7'd0);
        end
        o_spi_mosi = o_spi_sck && shreg[63];
    end

    // Datapath: request latch, bit/poll counters, shift registers, status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt  <= 7'd0;
            poll_cnt <= 24'd0;
            shreg    <= 64'd0;
            rx       <= 7'd0;
            status   <= 8'h00;
            err      <= 1'b0;
            addr     <= 22'd0;
            data     <= 32'd0;
            erase    <= 1'b0;
        end else begin
            bit_cnt <= ((next_state != state) || (state == S_IDLE)) ? 7'd0 : bit_cnt + 7'd1;
            if (accept) begin
                addr     <= i_wb_addr;
                data     <= i_wb_data;
                erase    <= i_erase;
                poll_cnt <= 24'd0;
                if (bad_write) err <= 1'b1;
            end
            if (shifting && (bit_cnt != 7'd0)) begin
                shreg <= {shreg[62:0], 1'b0};
                rx    <= {rx[5:0], i_spi_miso};
            end
            // Load the outgoing frame as a transfer state is entered.
            if (next_state != state) begin
                case (next_state)
                    S_WREN:  shreg <= {OP_WREN, 56'd0};
                    S_CMD:   shreg <= erase ? {OP_SE, byte_addr, 32'd0} : {OP_PP, byte_addr, data};
                    S_POLL:  shreg <= {OP_RDSR, 56'd0};
                    default: ;
                endcase
            end
            if ((state == S_POLL) && (bit_cnt == 7'd16)) begin
                status   <= {rx, i_spi_miso};
                poll_cnt <= poll_next;
                if (next_state == S_DONE) err <= i_spi_miso;
            end
        end
    end

endmodule
`default_nettype wire
